sdram_cmd_queue: RTL and testbench

- Upstream front-end for sdram_ctrl.
- Accepts read and write commands from a client over a valid/ready interface and buffers them in an in-order FIFO.
- Issues each command to the controller as a single-cycle i_wr_req/i_rd_req pulse, gated on the controller's o_ready.
- Captures read data on o_rd_rdy and returns it to the client over a valid/ready response port, with a timeout error flag.

---
 rtl/sdram_pkg.sv | 31 +++
 rtl/sdram_cmd_fifo.sv | 67 ++++++
 rtl/sdram_cmd_queue.sv | 193 +++++++++++++++++++
 tb/tb_sdram_cmd_queue.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared widths, queue entry and FSM state.
// Address layout is {bank, col, row}; widths are fixed here.
package sdram_pkg;

  localparam int BankWidth = 2;
  localparam int ColWidth = 8;
  localparam int RowWidth = 12;
  localparam int AddrWidth =
    BankWidth + ColWidth + RowWidth;
  localparam int DataWidth = 16;
  localparam int BurstLength = 1;

  typedef logic [AddrWidth-1:0] addr_t;

  typedef logic [BurstLength-1:0][DataWidth-1:0]
    burst_t;

  typedef struct packed {
    logic   we;
    addr_t  addr;
    burst_t wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_WAIT_RD
  } state_t;

endpackage

// File: rtl/sdram_cmd_fifo.sv
// sdram_cmd_fifo: in-order command FIFO of cmd_t entries.
// Ports: push/push_data in, pop in, head/count/full/empty out.
module sdram_cmd_fifo
  import sdram_pkg::*;
#(
  parameter int Depth = 4,
  localparam int PtrW = $clog2(Depth),
  localparam int CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  cmd_t            push_data,
  input  logic            pop,
  output cmd_t            head,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            empty
);

  cmd_t            mem [Depth];
  logic [PtrW-1:0] wr_q;
  logic [PtrW-1:0] rd_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            rdy_q;
  logic            push_ok;
  logic            pop_ok;

  assign push_ok = push && rdy_q;
  assign pop_ok  = pop && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Space flag is registered from the next count
  // so it is low while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != CntW'(Depth));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= push_data;
  end

  assign head  = mem[rd_q];
  assign count = cnt_q;
  assign full  = !rdy_q;
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/sdram_cmd_queue.sv
// sdram_cmd_queue: client command queue in front of sdram_ctrl.
// Ports: cmd valid/ready in, rsp valid/ready out, wr/rd req to ctrl.
module sdram_cmd_queue
  import sdram_pkg::*;
#(
  parameter int Depth = 4,
  parameter int HoldCycles = 2,
  parameter int RdTimeout = 64,
  localparam int CntW = $clog2(Depth) + 1
) (
  input  logic                 i_sys_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic                 i_cmd_we,
  input  logic [AddrWidth-1:0] i_cmd_addr,
  input  logic [DataWidth-1:0] i_cmd_wdata [BurstLength],
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [DataWidth-1:0] o_rsp_data [BurstLength],
  output logic                 o_rsp_err,
  output logic [CntW-1:0]      o_cmd_count,
  output logic                 o_wr_req,
  output logic [AddrWidth-1:0] o_wr_addr,
  output logic [DataWidth-1:0] o_wr_data [BurstLength],
  output logic                 o_rd_req,
  output logic [AddrWidth-1:0] o_rd_addr,
  input  logic [DataWidth-1:0] i_rd_data [BurstLength],
  input  logic                 i_rd_rdy,
  input  logic                 i_ctrl_ready
);

  localparam int HoldW = $clog2(HoldCycles + 1);
  localparam int ToW = $clog2(RdTimeout + 1);

  cmd_t             push_cmd;
  cmd_t             head;
  burst_t           rd_burst;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  state_t           state_q;
  state_t           state_d;
  logic             we_q;
  addr_t            addr_q;
  burst_t           wdata_q;
  logic [HoldW-1:0] hold_q;
  logic [ToW-1:0]   to_q;
  logic             hold_done;
  logic             to_done;
  logic             in_wait;
  logic             rd_hit;
  logic             rd_to;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  burst_t           rsp_data_q;

  always_comb begin
    push_cmd      = '0;
    rd_burst      = '0;
    push_cmd.we   = i_cmd_we;
    push_cmd.addr = i_cmd_addr;
    for (int b = 0; b < BurstLength; b++) begin
      push_cmd.wdata[b] = i_cmd_wdata[b];
      rd_burst[b]       = i_rd_data[b];
    end
  end

  assign push = i_cmd_valid && o_cmd_ready;

  sdram_cmd_fifo #(
    .Depth(Depth)
  ) u_fifo (
    .clk       (i_sys_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head),
    .count     (o_cmd_count),
    .full      (full),
    .empty     (empty)
  );

  assign o_cmd_ready = !full;

  assign hold_done =
    (hold_q == HoldW'(HoldCycles - 1));
  assign to_done =
    (to_q == ToW'(RdTimeout - 1));
  assign in_wait = (state_q == ST_WAIT_RD);
  assign rd_hit  = in_wait && i_rd_rdy;
  assign rd_to   = in_wait && !i_rd_rdy && to_done;

  // A read may only leave the queue once the
  // previous response has been taken.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty && i_ctrl_ready &&
            (head.we || !rsp_valid_q)) begin
          pop     = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_done)
          state_d = we_q ? ST_IDLE : ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (rd_hit || rd_to)
          state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_q <= '0;
      to_q   <= '0;
    end else begin
      if (state_q == ST_HOLD) hold_q <= hold_q + 1'b1;
      else                    hold_q <= '0;
      if (in_wait) to_q <= to_q + 1'b1;
      else         to_q <= '0;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (pop) begin
      we_q    <= head.we;
      addr_q  <= head.addr;
      wdata_q <= head.wdata;
    end
  end

  // Only one read is ever in flight, so a capture
  // never collides with a pending response.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else if (rd_hit) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= rd_burst;
    end else if (rd_to) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= 1'b1;
      rsp_data_q  <= '0;
    end else if (rsp_valid_q && i_rsp_ready) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end
  end

  assign o_wr_req    = (state_q == ST_REQ) && we_q;
  assign o_rd_req    = (state_q == ST_REQ) && !we_q;
  assign o_wr_addr   = addr_q;
  assign o_rd_addr   = addr_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_err   = rsp_err_q;

  always_comb begin
    for (int b = 0; b < BurstLength; b++) begin
      o_wr_data[b]  = wdata_q[b];
      o_rsp_data[b] = rsp_data_q[b];
    end
  end

endmodule

// File: tb/tb_sdram_cmd_queue.sv
// tb_sdram_cmd_queue: directed bench for sdram_cmd_queue.
// Drives client and controller sides, checks with assertions.
module tb_sdram_cmd_queue;

  localparam int ToLat = 1 + 2 + 64;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [21:0] cmd_addr;
  logic [15:0] cmd_wdata [1];
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data [1];
  logic        rsp_err;
  logic [2:0]  cmd_count;
  logic        wr_req;
  logic [21:0] wr_addr;
  logic [15:0] wr_data [1];
  logic        rd_req;
  logic [21:0] rd_addr;
  logic [15:0] rd_data [1];
  logic        rd_rdy;
  logic        ctrl_ready;

  int total;
  int bad;

  sdram_cmd_queue dut (
    .i_sys_clk    (clk),
    .i_rst_n      (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_we     (cmd_we),
    .i_cmd_addr   (cmd_addr),
    .i_cmd_wdata  (cmd_wdata),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_rsp_err    (rsp_err),
    .o_cmd_count  (cmd_count),
    .o_wr_req     (wr_req),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_rd_req     (rd_req),
    .o_rd_addr    (rd_addr),
    .i_rd_data    (rd_data),
    .i_rd_rdy     (rd_rdy),
    .i_ctrl_ready (ctrl_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic we,
                         input logic [21:0] a,
                         input logic [15:0] d);
    cmd_valid    = 1'b1;
    cmd_we       = we;
    cmd_addr     = a;
    cmd_wdata[0] = d;
  endtask

  logic [21:0] exp_addr [5];
  logic [15:0] exp_data [5];
  logic [21:0] got_addr [5];
  logic [15:0] got_data [5];
  int          n;
  int          nreq;
  int          reqs;
  logic        acc;
  logic        acc_now;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_we = 1'b0;
    cmd_addr = '0;
    cmd_wdata[0] = '0;
    rsp_ready = 1'b0;
    rd_data[0] = '0;
    rd_rdy = 1'b0;
    ctrl_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_addr[i] = 22'h10000 + 22'(i);
      exp_data[i] = 16'hA000 + 16'(i);
      got_addr[i] = '0;
      got_data[i] = '0;
    end

    // reset state
    repeat (3) tick();
    chk("rst_ready", cmd_ready, 0);
    chk("rst_count", cmd_count, 0);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", cmd_ready, 1);

    // single write, pulse at accept+2
    ctrl_ready = 1'b1;
    set_cmd(1'b1, 22'h0500D, 16'hBEEF);
    tick();
    cmd_valid = 1'b0;
    chk("wr_not_yet", wr_req, 0);
    chk("wr_count_1", cmd_count, 1);
    tick();
    chk("wr_pulse", wr_req, 1);
    chk("wr_addr", wr_addr, 22'h0500D);
    chk("wr_data", wr_data[0], 16'hBEEF);
    chk("wr_no_rd", rd_req, 0);
    tick();
    chk("wr_one_cycle", wr_req, 0);
    repeat (4) tick();
    chk("wr_no_rsp", rsp_valid, 0);

    // read, data 8 cycles after request
    set_cmd(1'b0, 22'h0500D, 16'h0000);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rd_pulse", rd_req, 1);
    chk("rd_addr", rd_addr, 22'h0500D);
    repeat (8) tick();
    rd_rdy = 1'b1;
    rd_data[0] = 16'hBEEF;
    chk("rd_rsp_early", rsp_valid, 0);
    tick();
    rd_rdy = 1'b0;
    rd_data[0] = 16'h1234;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_data", rsp_data[0], 16'hBEEF);
    chk("rd_rsp_err", rsp_err, 0);
    repeat (3) tick();
    chk("rd_rsp_held", rsp_valid, 1);
    chk("rd_rsp_stable", rsp_data[0], 16'hBEEF);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rd_rsp_clear", rsp_valid, 0);

    // fill FIFO with controller stalled
    ctrl_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b1, exp_addr[i], exp_data[i]);
      chk($sformatf("fill_ready_%0d", i),
          cmd_ready, 1);
      tick();
    end
    set_cmd(1'b1, exp_addr[4], exp_data[4]);
    chk("full_ready", cmd_ready, 0);
    chk("full_count", cmd_count, 4);
    reqs = 0;
    repeat (3) begin
      tick();
      reqs += int'(wr_req | rd_req);
    end
    chk("full_no_req", reqs, 0);
    chk("full_count_hold", cmd_count, 4);
    ctrl_ready = 1'b1;
    acc  = 1'b0;
    nreq = 0;
    for (int c = 0; c < 80 && nreq < 5; c++) begin
      acc_now = cmd_valid && cmd_ready;
      tick();
      if (acc_now) begin
        cmd_valid = 1'b0;
        acc = 1'b1;
      end
      if (wr_req) begin
        got_addr[nreq] = wr_addr;
        got_data[nreq] = wr_data[0];
        nreq++;
      end
    end
    chk("fifth_accepted", acc, 1);
    chk("order_req_count", nreq, 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("order_addr_%0d", i),
          got_addr[i], exp_addr[i]);
      chk($sformatf("order_data_%0d", i),
          got_data[i], exp_data[i]);
    end
    repeat (4) tick();

    // two reads, second waits for rsp consume
    set_cmd(1'b0, 22'h20001, 16'h0);
    tick();
    set_cmd(1'b0, 22'h20002, 16'h0);
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!rd_req && n < 20) begin
      tick();
      n++;
    end
    chk("rdA_seen", rd_req, 1);
    chk("rdA_addr", rd_addr, 22'h20001);
    repeat (4) tick();
    rd_rdy = 1'b1;
    rd_data[0] = 16'h1111;
    tick();
    rd_rdy = 1'b0;
    chk("rdA_rsp", rsp_valid, 1);
    chk("rdA_data", rsp_data[0], 16'h1111);
    reqs = 0;
    repeat (20) begin
      tick();
      reqs += int'(rd_req);
    end
    chk("rdB_withheld", reqs, 0);
    chk("rdA_still", rsp_data[0], 16'h1111);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n = 0;
    while (!rd_req && n < 20) begin
      tick();
      n++;
    end
    chk("rdB_seen", rd_req, 1);
    chk("rdB_addr", rd_addr, 22'h20002);
    repeat (4) tick();
    rd_rdy = 1'b1;
    rd_data[0] = 16'h2222;
    tick();
    rd_rdy = 1'b0;
    chk("rdB_rsp", rsp_valid, 1);
    chk("rdB_data", rsp_data[0], 16'h2222);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // read timeout, then queued write proceeds
    set_cmd(1'b0, 22'h30003, 16'h0);
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!rd_req && n < 20) begin
      tick();
      n++;
    end
    chk("to_rd_seen", rd_req, 1);
    set_cmd(1'b1, 22'h30004, 16'h5555);
    tick();
    cmd_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    chk("to_latency", n, ToLat);
    chk("to_err", rsp_err, 1);
    chk("to_data", rsp_data[0], 0);
    n = 0;
    while (!wr_req && n < 20) begin
      tick();
      n++;
    end
    chk("to_next_wr", wr_req, 1);
    chk("to_next_addr", wr_addr, 22'h30004);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    repeat (4) tick();

    // reset while in HOLD with 3 queued
    for (int i = 1; i <= 4; i++) begin
      set_cmd(1'b1, 22'h40000 + 22'(i), 16'h7000);
      tick();
    end
    cmd_valid = 1'b0;
    chk("hold_count", cmd_count, 3);
    chk("hold_addr", wr_addr, 22'h40001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", cmd_ready, 0);
    chk("arst_count", cmd_count, 0);
    chk("arst_wr_req", wr_req, 0);
    chk("arst_rd_req", rd_req, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_wr_data", wr_data[0], 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    tick();
    rst_n = 1'b1;
    reqs = 0;
    repeat (10) begin
      tick();
      reqs += int'(wr_req | rd_req);
    end
    chk("post_rst_no_req", reqs, 0);
    chk("post_rst_count", cmd_count, 0);
    chk("post_rst_ready", cmd_ready, 1);
    set_cmd(1'b1, 22'h40005, 16'h8888);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("post_rst_wr", wr_req, 1);
    chk("post_rst_addr", wr_addr, 22'h40005);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
